// File: rtl/exp_table_reader_if.sv
// Bus between the exp-sigma generator / lookup client and exp_table_reader.
// master drives writes and lookups; slave is the table reader itself.
interface exp_table_reader_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10
);
  logic [DATA_W-1:0] iWrData;
  logic              iWrValid;
  logic [ADDR_W-1:0] iWrAddr;
  logic              iWrDone;
  logic              iRdReq;
  logic [ADDR_W-1:0] iRdAddr;
  logic [DATA_W-1:0] oRdData;
  logic              oRdValid;
  logic              oRdErr;
  logic              oReady;
  logic [ADDR_W:0]   oCount;
  logic              oLoadErr;

  modport master (
    output iWrData, iWrValid, iWrAddr, iWrDone, iRdReq, iRdAddr,
    input  oRdData, oRdValid, oRdErr, oReady, oCount, oLoadErr
  );

  modport slave (
    input  iWrData, iWrValid, iWrAddr, iWrDone, iRdReq, iRdAddr,
    output oRdData, oRdValid, oRdErr, oReady, oCount, oLoadErr
  );
endinterface

// File: rtl/exp_table_reader.sv
// Exp lookup table: loaded by the exp-sigma generator, then read with a 2-cycle pipelined lookup.
// Optional macro EXP_TABLE_ORDER_CHECK_EN enables sequential-load checking and oLoadErr.
module exp_table_reader #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10
) (
  input logic                 CLK,
  input logic                 iRST_n,
  exp_table_reader_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdDataQ;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  logic              loadErr;
  logic              loadErrNext;
  logic              ready;
  logic              doneTaken;
  logic              doneFail;
  logic              rdAccept;
  logic              rdReject;
  logic              rdVld1;
  logic              rdErr1;
  logic              rdValid;
  logic              rdErr;
  logic [DATA_W-1:0] rdData;

  // State register
  always_ff @(posedge CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: a done pulse only counts once a load is in progress or starts this cycle
  always_comb begin
    stateNext = state;
    if (doneTaken) begin
      stateNext = doneFail ? EMPTY : READY;
    end else if (bus.iWrValid) begin
      stateNext = LOADING;
    end
  end

  // Per-cycle control: load counting, order checking and lookup acceptance
  always_comb begin
    countNext   = count;
    loadErrNext = loadErr;
    doneFail    = 1'b0;
    doneTaken   = bus.iWrDone && ((state == LOADING) || bus.iWrValid);
    rdAccept    = bus.iRdReq && (state == READY);
    rdReject    = bus.iRdReq && (state != READY);

    if (bus.iWrValid) begin
      if (state != LOADING) begin
        countNext = CNT_W'(1);
      end else if (count != CNT_MAX) begin
        countNext = count + CNT_W'(1);
      end
    end

`ifdef EXP_TABLE_ORDER_CHECK_EN
    if (bus.iWrValid) begin
      if (state != LOADING) begin
        loadErrNext = (bus.iWrAddr != '0);
      end else if (CNT_W'(bus.iWrAddr) != count) begin
        loadErrNext = 1'b1;
      end
    end
    // A same-cycle write is counted and checked before the done is judged
    if (doneTaken && (loadErrNext || (countNext != CNT_MAX))) begin
      loadErrNext = 1'b1;
    end
    doneFail = doneTaken && loadErrNext;
`else
    loadErrNext = 1'b0;
`endif
  end

  // Table storage and RAM read register; contents are intentionally not reset
  always_ff @(posedge CLK) begin
    if (bus.iWrValid) begin
      mem[bus.iWrAddr] <= bus.iWrData;
    end
    if (rdAccept) begin
      rdDataQ <= mem[bus.iRdAddr];
    end
  end

  // Registered outputs and the lookup response pipeline
  always_ff @(posedge CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      count   <= '0;
      loadErr <= 1'b0;
      ready   <= 1'b0;
      rdVld1  <= 1'b0;
      rdErr1  <= 1'b0;
      rdValid <= 1'b0;
      rdErr   <= 1'b0;
      rdData  <= '0;
    end else begin
      count   <= countNext;
      loadErr <= loadErrNext;
      ready   <= (stateNext == READY);
      rdVld1  <= rdAccept;
      rdErr1  <= rdReject;
      rdValid <= rdVld1;
      rdErr   <= rdErr1;
      if (rdVld1) begin
        rdData <= rdDataQ;
      end
    end
  end

  assign bus.oRdData  = rdData;
  assign bus.oRdValid = rdValid;
  assign bus.oRdErr   = rdErr;
  assign bus.oReady   = ready;
  assign bus.oCount   = count;
  assign bus.oLoadErr = loadErr;

endmodule

// File: doc/exp_table_reader.md
EXP_TABLE_READER -- requirements
Module: exp_table_reader

Interface
REQ-001 Parameter DATA_W, default 18, table entry width.
REQ-002 Parameter ADDR_W, default 10, table address width; depth = 2**ADDR_W.
REQ-003 CLK  input  1  single clock; all logic rising-edge.
REQ-004 iRST_n  input  1  reset, asynchronous, active-low.
REQ-005 iWrData  input  DATA_W  table entry from the exp-sigma generator.
REQ-006 iWrValid  input  1  iWrData/iWrAddr valid this cycle.
REQ-007 iWrAddr  input  ADDR_W  entry address.
REQ-008 iWrDone  input  1  one-cycle pulse, generator finished.
REQ-009 iRdReq  input  1  lookup request, one per cycle max.
REQ-010 iRdAddr  input  ADDR_W  lookup address.
REQ-011 oRdData  output  DATA_W  lookup result.
REQ-012 oRdValid  output  1  oRdData valid, one-cycle pulse per accepted request.
REQ-013 oRdErr  output  1  one-cycle pulse, request rejected (table not READY).
REQ-014 oReady  output  1  high in READY state.
REQ-015 oCount  output  ADDR_W+1  entries written in current load.
REQ-016 oLoadErr  output  1  sticky load-order error (see Configuration).

Function
REQ-017 States EMPTY, LOADING, READY; reset -> EMPTY.
REQ-018 EMPTY or READY, iWrValid=1 -> LOADING; that write is stored and oCount restarts at 1.
REQ-019 LOADING, iWrValid=1 -> mem[iWrAddr] <= iWrData, oCount increments, saturating at 2**ADDR_W.
REQ-020 LOADING, iWrDone=1 -> READY next cycle; a write in the same cycle is stored and counted first.
REQ-021 iWrDone in EMPTY or READY without iWrValid: ignored, state unchanged.
REQ-022 iWrDone with iWrValid in EMPTY or READY: the write is stored, oCount=1, state -> READY.
REQ-023 READY, iRdReq=1 -> oRdValid=1 and oRdData=mem[iRdAddr] exactly 2 cycles later (RAM read register + output register); fully pipelined, back-to-back requests each answered.
REQ-024 iRdReq=1 while not READY -> oRdErr=1 exactly 2 cycles later, oRdValid=0, oRdData holds previous value.
REQ-025 Acceptance is decided by the state in the request cycle; a reload starting after acceptance does not cancel in-flight reads.
REQ-026 Same-cycle iRdReq and iWrValid in READY: read is accepted and returns the pre-write contents; state -> LOADING.
REQ-027 oRdValid and oRdErr never high together.
REQ-028 oReady = (state == READY), registered.

Reset
REQ-029 iRST_n low -> state EMPTY, oRdValid=0, oRdErr=0, oReady=0, oCount=0, oRdData=0, oLoadErr=0, read pipeline flushed, asynchronously.
REQ-030 Memory contents are not reset; undefined until written.
REQ-031 Reset mid-load or mid-read: in-flight reads are discarded, with no oRdValid or oRdErr pulse after deassertion.

Configuration
REQ-032 Macro EXP_TABLE_ORDER_CHECK_EN.
REQ-033 Defined: in LOADING, every write must carry iWrAddr == oCount (sequential from 0).
REQ-034 Defined: a mismatch sets oLoadErr, which stays set until the next load start or reset; the data is still stored.
REQ-035 Defined: iWrDone with oLoadErr=1 -> EMPTY instead of READY.
REQ-036 Defined: iWrDone with oCount != 2**ADDR_W -> sets oLoadErr and goes to EMPTY.
REQ-037 Not defined: oLoadErr is tied to 0, no address checking, and iWrDone always -> READY.

Verification
REQ-038 Stream addr 0..1023 with data = 5*addr, then iWrDone -> oReady=1, oCount=1024; iRdReq at addr 7 -> oRdValid 2 cycles later with oRdData=35.
REQ-039 iRdReq at addr 3 in EMPTY -> oRdErr pulse 2 cycles later, oRdValid stays 0.
REQ-040 READY, then 4 back-to-back reads at addrs 0,1,2,1023 -> 4 consecutive oRdValid pulses with data 0,5,10,5115.
REQ-041 READY, then a reload starts (write addr 0 data 99) in the same cycle as a read of addr 0 -> read returns 0; a later read after iWrDone returns 99.
REQ-042 Reset asserted after 500 writes -> next cycle oCount=0, state EMPTY, oReady=0; a read issued 1 cycle before reset yields no pulse.
REQ-043 With EXP_TABLE_ORDER_CHECK_EN: writes at addrs 0,1,3 -> oLoadErr=1 on the third; iWrDone -> oReady stays 0.
